baud_arbiter: RTL and testbench

Owns the single shared baud-rate divider counter of the async link and time-shares it between the transmitter (TX) and receiver (RX) of a half-duplex channel. Holds the runtime-programmable divisor, grants the counter to one requester at a time with round-robin priority, and emits one-cycle bit-rate tick strobes to the owner. RX sessions start with a half-period alignment phase so RX samples land mid-bit. Sits between the configuration interface and the TX/RX shift engines, replacing free-running divided clocks with clk_in-synchronous enables.

---
 rtl/baud_arbiter_pkg.sv | 16 +
 rtl/baud_arbiter_tc_counter.sv | 28 ++
 rtl/baud_arbiter.sv | 109 ++++++++++
 tb/tb_baud_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/baud_arbiter_pkg.sv
// rtl/baud_arbiter_pkg.sv - shared encodings for the baud divider arbiter
package baud_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TX_RUN   = 2'd1,
    RX_ALIGN = 2'd2,
    RX_RUN   = 2'd3
  } state_t;

  localparam logic OWN_TX = 1'b0;
  localparam logic OWN_RX = 1'b1;

  localparam logic [27:0] MIN_DIV = 28'd2;

endpackage

// File: rtl/baud_arbiter_tc_counter.sv
// rtl/baud_arbiter_tc_counter.sv - wrapping counter with clear/enable and terminal-count flag
module tc_counter #(
  parameter int WIDTH = 28
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;

  // tc is high for the single cycle the count sits at its terminal value
  assign tc = en && (cnt_q == tc_val);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/baud_arbiter.sv
// rtl/baud_arbiter.sv - time-shares one baud divider between TX and RX with round-robin grant
module baud_arbiter
  import baud_arbiter_pkg::*;
#(
  parameter int             WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(5208),
  parameter logic [WIDTH-1:0] MIN_DIV     = WIDTH'(baud_arbiter_pkg::MIN_DIV)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_err,
  output logic [WIDTH-1:0] div_q,
  input  logic             tx_req,
  output logic             tx_grant,
  output logic             tick_tx,
  input  logic             rx_req,
  output logic             rx_grant,
  output logic             tick_rx,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic             release_now;
  logic             tick_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [WIDTH-1:0] tc_val;
  logic [WIDTH-1:0] div_clamped;

  assign div_clamped = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
  // the alignment phase counts half a bit so RX samples land mid-bit
  assign tc_val  = (state_q == RX_ALIGN) ? (div_q >> 1) - WIDTH'(1) : div_q - WIDTH'(1);
  assign cnt_clr = (state_q == IDLE) || release_now;
  assign cnt_en  = !cnt_clr;
  assign busy    = (state_q != IDLE);

  tc_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (tc_val),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    release_now  = 1'b0;
    tick_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_req && rx_req) begin
          state_d = (last_owner_q == OWN_TX) ? RX_ALIGN : TX_RUN;
        end else if (tx_req) begin
          state_d = TX_RUN;
        end else if (rx_req) begin
          state_d = RX_ALIGN;
        end
      end
      TX_RUN: begin
        if (!tx_req) begin
          release_now  = 1'b1;
          state_d      = IDLE;
          last_owner_d = OWN_TX;
        end else begin
          tick_d = cnt_tc;
        end
      end
      RX_ALIGN, RX_RUN: begin
        // release beats a coinciding terminal count
        if (!rx_req) begin
          release_now  = 1'b1;
          state_d      = IDLE;
          last_owner_d = OWN_RX;
        end else begin
          tick_d = cnt_tc;
          if (cnt_tc) state_d = RX_RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_TX;
      div_q        <= DEFAULT_DIV;
      tx_grant     <= 1'b0;
      rx_grant     <= 1'b0;
      tick_tx      <= 1'b0;
      tick_rx      <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      tx_grant     <= (state_d == TX_RUN);
      rx_grant     <= (state_d == RX_ALIGN) || (state_d == RX_RUN);
      tick_tx      <= tick_d && (state_q == TX_RUN);
      tick_rx      <= tick_d && (state_q != TX_RUN);
      cfg_err      <= cfg_we && (state_q != IDLE);
      if (cfg_we && (state_q == IDLE)) div_q <= div_clamped;
    end
  end

endmodule

// File: tb/tb_baud_arbiter.sv
// tb/tb_baud_arbiter.sv - directed self-checking bench for baud_arbiter
module tb_baud_arbiter;

  localparam int WIDTH = 28;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_err;
  logic [WIDTH-1:0] div_q;
  logic             tx_req, tx_grant, tick_tx;
  logic             rx_req, rx_grant, tick_rx;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  baud_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .div_q    (div_q),
    .tx_req   (tx_req),
    .tx_grant (tx_grant),
    .tick_tx  (tick_tx),
    .rx_req   (rx_req),
    .rx_grant (rx_grant),
    .tick_rx  (tick_rx),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs change and outputs are sampled on negedge
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_div(input logic [WIDTH-1:0] d);
    cfg_we  = 1'b1;
    cfg_div = d;
    step();
    cfg_we  = 1'b0;
  endtask

  // cycles 1..ncyc after the req edge: owner tick expected at first, first+period, ...
  task automatic run_ticks(input string tag, input int ncyc, input int first,
                           input int period, input bit is_tx);
    for (int c = 1; c <= ncyc; c++) begin
      logic exp_t;
      step();
      exp_t = (c >= first) && (((c - first) % period) == 0);
      check({tag, "_tick"}, is_tx ? tick_tx : tick_rx, exp_t);
      check({tag, "_othertick"}, is_tx ? tick_rx : tick_tx, 0);
      if (c == 1) begin
        check({tag, "_grant"}, is_tx ? tx_grant : rx_grant, 1);
        check({tag, "_nogrant"}, is_tx ? rx_grant : tx_grant, 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_div = '0; tx_req = 1'b0; rx_req = 1'b0;
    @(negedge clk_in);
    do_reset();
    check("rst_div", div_q, 5208);
    check("rst_txg", tx_grant, 0);
    check("rst_rxg", rx_grant, 0);
    check("rst_ticks", {tick_tx, tick_rx}, 0);
    check("rst_busy", busy, 0);
    check("rst_err", cfg_err, 0);

    write_div(10);
    check("wr_div10", div_q, 10);
    check("wr_err", cfg_err, 0);

    // TX alone: ticks at 11, 21, 31
    tx_req = 1'b1;
    run_ticks("tx1", 32, 11, 10, 1'b1);
    tx_req = 1'b0;
    step();
    check("tx1_rel_grant", tx_grant, 0);
    check("tx1_rel_busy", busy, 0);

    // RX alone: align 5 then period 10
    rx_req = 1'b1;
    run_ticks("rx1", 27, 6, 10, 1'b0);
    rx_req = 1'b0;
    step();
    check("rx1_rel_grant", rx_grant, 0);
    check("rx1_rel_busy", busy, 0);

    // last owner RX -> simultaneous reqs grant TX
    tx_req = 1'b1; rx_req = 1'b1;
    step();
    check("rr_tx_grant", tx_grant, 1);
    check("rr_rx_grant", rx_grant, 0);
    tx_req = 1'b0; rx_req = 1'b0;
    step();
    check("rr_rel_busy", busy, 0);

    // after reset both reqs -> RX wins, handoff to TX on release
    do_reset();
    write_div(10);
    tx_req = 1'b1; rx_req = 1'b1;
    run_ticks("both_rx", 30, 6, 10, 1'b0);
    rx_req = 1'b0;
    step();
    check("hand_c31_rxg", rx_grant, 0);
    check("hand_c31_txg", tx_grant, 0);
    check("hand_c31_busy", busy, 0);
    for (int c = 32; c <= 42; c++) begin
      step();
      if (c == 32) check("hand_c32_txg", tx_grant, 1);
      check("hand_tick_tx", tick_tx, (c == 42) ? 1 : 0);
    end
    tx_req = 1'b0;
    step();

    // clamp in IDLE, dropped write while busy
    write_div(1);
    check("clamp_div", div_q, 2);
    tx_req = 1'b1;
    step();
    check("clamp_grant", tx_grant, 1);
    cfg_we = 1'b1; cfg_div = 7;
    step();
    cfg_we = 1'b0;
    check("busy_err", cfg_err, 1);
    check("busy_div", div_q, 2);
    step();
    check("busy_err_pulse", cfg_err, 0);
    check("div2_tick", tick_tx, 1);
    step();
    check("div2_notick", tick_tx, 0);
    tx_req = 1'b0;
    step();
    write_div(10);

    // release coincides with terminal count: no tick
    tx_req = 1'b1;
    run_ticks("tc_rel", 10, 11, 10, 1'b1);
    tx_req = 1'b0;
    step();
    check("tc_rel_tick", tick_tx, 0);
    check("tc_rel_grant", tx_grant, 0);
    check("tc_rel_busy", busy, 0);

    // reset during RX_RUN
    rx_req = 1'b1;
    run_ticks("rx2", 8, 6, 10, 1'b0);
    rst_n = 1'b0;
    step();
    check("mid_rst_grants", {tx_grant, rx_grant}, 0);
    check("mid_rst_ticks", {tick_tx, tick_rx}, 0);
    check("mid_rst_div", div_q, 5208);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1; rx_req = 1'b0;
    step();
    tx_req = 1'b1; rx_req = 1'b1;
    step();
    check("post_rst_rxg", rx_grant, 1);
    check("post_rst_txg", tx_grant, 0);
    tx_req = 1'b0; rx_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
